// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encodings, instruction kinds, IR decode.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package jtag_pkg;

    localparam int unsigned ID_DR_WIDTH = 32;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {
        CHAIN,
        IDCODE,
        BYPASS
    } instr_kind_e;

    // Opcodes below chain_num select a chain, all-ones-minus-one is IDCODE,
    // and everything else (including all ones) falls back to BYPASS.
    function automatic instr_kind_e decode_ir(input logic [15:0] ir,
                                              input int unsigned ir_width,
                                              input int unsigned chain_num);
        instr_kind_e kind;
        int unsigned v;
        v = 32'(ir);
        if (v < chain_num)
            kind = CHAIN;
        else if (v == ((32'd1 << ir_width) - 32'd2))
            kind = IDCODE;
        else
            kind = BYPASS;
        return kind;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP machine: tms -> state. Ports: tck, trst_n, tms in; state, tlr out.
// Latency: state moves on every tck rise; outputs are the registered state.
// Backpressure: none; the machine is paced entirely by tck.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_e state,
    output logic       tlr
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n)
            state_q <= TLR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        state = state_q;
        tlr   = (state_q == TLR);
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, IDCODE/BYPASS DRs, chain strobes/select and TDO mux.
// Ports: tck/trst_n/tms/tdi in, tdo/tdo_oe out; chain_* fan-out/fan-in; state/tlr.
// Latency: shifts on tck rise, TDO half a tck later on fall. Backpressure: none.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned CHAIN_NUM = 2,
    parameter int unsigned IR_WIDTH  = 4,
    parameter logic [31:0] IDCODE    = 32'h1495_11C3
) (
    input  logic                 tck_i,
    input  logic                 trst_n_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 tdo_oe_o,
    output logic                 chain_tdi_o,
    input  logic [CHAIN_NUM-1:0] chain_tdo_i,
    output logic [CHAIN_NUM-1:0] chain_sel_o,
    output logic                 capture_dr_o,
    output logic                 shift_dr_o,
    output logic                 update_dr_o,
    output logic [3:0]           tap_state_o,
    output logic                 tlr_o
);

    localparam logic [IR_WIDTH-1:0] IDCODE_OP  = {{(IR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e              state;
    logic [IR_WIDTH-1:0]     ir_shift;
    logic [IR_WIDTH-1:0]     ir;
    logic [ID_DR_WIDTH-1:0]  id_dr;
    logic                    bypass_dr;
    instr_kind_e             kind;
    logic                    chain_act;
    logic                    chain_bit;

    jtag_tap_fsm u_fsm (
        .tck    (tck_i),
        .trst_n (trst_n_i),
        .tms    (tms_i),
        .state  (state),
        .tlr    (tlr_o)
    );

    assign tap_state_o = state;
    assign chain_tdi_o = tdi_i;

    assign kind      = decode_ir(16'(ir), IR_WIDTH, CHAIN_NUM);
    assign chain_act = (kind == jtag_pkg::CHAIN);

    // ir only changes on tck fall, so the select never moves during a shift.
    always_comb begin
        chain_sel_o = '0;
        for (int i = 0; i < int'(CHAIN_NUM); i++)
            chain_sel_o[i] = chain_act && (ir == IR_WIDTH'(i));
    end

    assign chain_bit    = |(chain_tdo_i & chain_sel_o);
    assign capture_dr_o = chain_act && (state == CAP_DR);
    assign shift_dr_o   = chain_act && (state == SH_DR);
    assign update_dr_o  = chain_act && (state == UPD_DR);

    // IR shift register: rise-edge, keyed on the pre-edge state.
    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i)
            ir_shift <= IDCODE_OP;
        else if (state == CAP_IR)
            ir_shift <= IR_CAPTURE;
        else if (state == SH_IR)
            ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
    end

    // Built-in DRs only move when their instruction is the active one.
    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            id_dr     <= '0;
            bypass_dr <= 1'b0;
        end else if (state == CAP_DR) begin
            if (kind == jtag_pkg::IDCODE)
                id_dr <= IDCODE;
            if (kind == jtag_pkg::BYPASS)
                bypass_dr <= 1'b0;
        end else if (state == SH_DR) begin
            if (kind == jtag_pkg::IDCODE)
                id_dr <= {tdi_i, id_dr[ID_DR_WIDTH-1:1]};
            if (kind == jtag_pkg::BYPASS)
                bypass_dr <= tdi_i;
        end
    end

    // Active instruction is committed on the fall inside UPD_IR or TLR.
    always_ff @(negedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i)
            ir <= IDCODE_OP;
        else if (state == UPD_IR)
            ir <= ir_shift;
        else if (state == TLR)
            ir <= IDCODE_OP;
    end

    always_ff @(negedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            case (state)
                SH_IR: begin
                    tdo_o    <= ir_shift[0];
                    tdo_oe_o <= 1'b1;
                end
                SH_DR: begin
                    tdo_oe_o <= 1'b1;
                    if (chain_act)
                        tdo_o <= chain_bit;
                    else if (kind == jtag_pkg::IDCODE)
                        tdo_o <= id_dr[0];
                    else
                        tdo_o <= bypass_dr;
                end
                default: begin
                    tdo_o    <= 1'b0;
                    tdo_oe_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
module tb_jtag_tap_ctrl;

    localparam int          CN   = 2;
    localparam int          W    = 4;
    localparam logic [31:0] IDC  = 32'h1495_11C3;
    localparam int          IDOP = 14;

    logic          tck = 1'b0;
    logic          trst_n = 1'b0;
    logic          tms = 1'b0;
    logic          tdi = 1'b0;
    logic [CN-1:0] chain_tdo = '0;
    logic          tdo, tdo_oe, chain_tdi, capture_dr, shift_dr, update_dr, tlr;
    logic [CN-1:0] chain_sel;
    logic [3:0]    tap_state;

    jtag_tap_ctrl #(.CHAIN_NUM(CN), .IR_WIDTH(W), .IDCODE(IDC)) dut (
        .tck_i        (tck),
        .trst_n_i     (trst_n),
        .tms_i        (tms),
        .tdi_i        (tdi),
        .tdo_o        (tdo),
        .tdo_oe_o     (tdo_oe),
        .chain_tdi_o  (chain_tdi),
        .chain_tdo_i  (chain_tdo),
        .chain_sel_o  (chain_sel),
        .capture_dr_o (capture_dr),
        .shift_dr_o   (shift_dr),
        .update_dr_o  (update_dr),
        .tap_state_o  (tap_state),
        .tlr_o        (tlr)
    );

    always #5 tck = ~tck;

    int errors = 0;
    int checks = 0;

    // Behavioural model: transition table, integer IR, DR as a bit queue.
    int   nxt0 [16];
    int   nxt1 [16];
    int   m_state, m_ir, m_irsh;
    bit   m_dq [$];
    logic m_tdo, m_oe;
    logic [31:0] idc_v;

    logic [63:0] obs, obs_ref;
    int          nobs;
    int          n_cap, n_sh, n_upd;
    int          cyc = 0;
    logic [31:0] pat = 32'hB2C5_3A96;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int kind_of(input int ir);
        if (ir < CN) return 0;          // chain
        if (ir == IDOP) return 1;       // idcode
        return 2;                       // bypass
    endfunction

    task automatic model_reset();
        m_state = 15;
        m_ir    = IDOP;
        m_irsh  = IDOP;
        m_dq.delete();
        m_tdo   = 1'b0;
        m_oe    = 1'b0;
    endtask

    task automatic model_rise(input logic t_ms, input logic t_di);
        int s;
        int k;
        s = m_state;
        k = kind_of(m_ir);
        if (s == 'hE) m_irsh = 1;
        if (s == 'hA) m_irsh = (m_irsh >> 1) | (int'(t_di) << (W - 1));
        if (s == 'h6) begin
            if (k == 1) begin
                m_dq.delete();
                for (int i = 0; i < 32; i++) m_dq.push_back(idc_v[i]);
            end else if (k == 2) begin
                m_dq.delete();
                m_dq.push_back(1'b0);
            end
        end
        if (s == 'h2 && k != 0 && m_dq.size() > 0) begin
            void'(m_dq.pop_front());
            m_dq.push_back(t_di);
        end
        m_state = t_ms ? nxt1[s] : nxt0[s];
    endtask

    task automatic model_fall();
        if (m_state == 'hA) begin
            m_tdo = m_irsh[0];
            m_oe  = 1'b1;
        end else if (m_state == 'h2) begin
            m_oe = 1'b1;
            if (kind_of(m_ir) == 0) m_tdo = chain_tdo[m_ir];
            else m_tdo = (m_dq.size() > 0) ? m_dq[0] : 1'b0;
        end else begin
            m_tdo = 1'b0;
            m_oe  = 1'b0;
        end
        if (m_state == 'hD) m_ir = m_irsh;
        else if (m_state == 'hF) m_ir = IDOP;
    endtask

    task automatic compare_all();
        int k;
        logic [CN-1:0] sel;
        k = kind_of(m_ir);
        sel = (k == 0) ? CN'(1 << m_ir) : '0;
        chk("tap_state", 32'(tap_state), 32'(m_state));
        chk("tlr", 32'(tlr), 32'(m_state == 15));
        chk("tdo_oe", 32'(tdo_oe), 32'(m_oe));
        chk("tdo", 32'(tdo), 32'(m_tdo));
        chk("chain_sel", 32'(chain_sel), 32'(sel));
        chk("capture_dr", 32'(capture_dr), 32'(k == 0 && m_state == 'h6));
        chk("shift_dr", 32'(shift_dr), 32'(k == 0 && m_state == 'h2));
        chk("update_dr", 32'(update_dr), 32'(k == 0 && m_state == 'h5));
        chk("chain_tdi", 32'(chain_tdi), 32'(tdi));
    endtask

    // One tck period: drive while tck low, model both edges, compare after the fall.
    task automatic step(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        chain_tdo = {pat[cyc % 32], pat[(cyc + 7) % 32]};
        cyc++;
        @(posedge tck);
        model_rise(t_ms, t_di);
        @(negedge tck);
        model_fall();
        #1;
        compare_all();
        if (m_state == 'h2 || m_state == 'hA) begin
            obs[nobs]     = tdo;
            obs_ref[nobs] = chain_tdo[1];
            nobs++;
        end
        n_cap += int'(capture_dr);
        n_sh  += int'(shift_dr);
        n_upd += int'(update_dr);
    endtask

    task automatic load_ir(input logic [31:0] v);
        nobs = 0;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < W; i++) step(i == W - 1, v[i]);
        step(1, 0); step(0, 0);
    endtask

    task automatic scan_dr(input logic [63:0] bits, input int n);
        nobs = 0; n_cap = 0; n_sh = 0; n_upd = 0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) step(i == n - 1, bits[i]);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nxt0[15] = 12; nxt1[15] = 15;
        nxt0[12] = 12; nxt1[12] = 7;
        nxt0[7]  = 6;  nxt1[7]  = 4;
        nxt0[6]  = 2;  nxt1[6]  = 1;
        nxt0[2]  = 2;  nxt1[2]  = 1;
        nxt0[1]  = 3;  nxt1[1]  = 5;
        nxt0[3]  = 3;  nxt1[3]  = 0;
        nxt0[0]  = 2;  nxt1[0]  = 5;
        nxt0[5]  = 12; nxt1[5]  = 7;
        nxt0[4]  = 14; nxt1[4]  = 15;
        nxt0[14] = 10; nxt1[14] = 9;
        nxt0[10] = 10; nxt1[10] = 9;
        nxt0[9]  = 11; nxt1[9]  = 13;
        nxt0[11] = 11; nxt1[11] = 8;
        nxt0[8]  = 10; nxt1[8]  = 13;
        nxt0[13] = 12; nxt1[13] = 7;
        idc_v = IDC;
        obs = '0; obs_ref = '0; nobs = 0;
        n_cap = 0; n_sh = 0; n_upd = 0;
        model_reset();

        // Reset held for 3 tck, released while tck is low.
        repeat (3) @(negedge tck);
        #1;
        compare_all();
        chk("rst_state_lit", 32'(tap_state), 32'hF);
        chk("rst_tlr_lit", 32'(tlr), 32'h1);
        trst_n = 1'b1;

        // IDCODE read: TMS 0,1,0,0 then 32 shift cycles.
        step(0, 0);
        scan_dr(64'h0, 32);
        chk("idcode_bits", obs[31:0], 32'h1495_11C3);
        chk("idcode_nbits", 32'(nobs), 32'd32);

        // IR scan of 1111: capture pattern 01 comes out first, then bypass.
        load_ir(32'hF);
        chk("ir_capture_out", 32'(obs[3:0]), 32'h1);
        chk("ir_nbits", 32'(nobs), 32'd4);
        scan_dr(64'h5, 4);
        chk("bypass_allones", 32'(obs[3:0]), 32'hA);
        chk("bypass_sel", 32'(chain_sel), 32'h0);

        // Chain 1.
        load_ir(32'h1);
        chk("chain1_sel_lit", 32'(chain_sel), 32'h2);
        scan_dr(64'h3, 4);
        chk("chain1_ncap", 32'(n_cap), 32'd1);
        chk("chain1_nshift", 32'(n_sh), 32'd4);
        chk("chain1_nupd", 32'(n_upd), 32'd1);
        chk("chain1_tdo", 32'(obs[3:0]), 32'(obs_ref[3:0]));

        // Undefined opcode behaves as BYPASS.
        load_ir(32'h5);
        chk("undef_sel", 32'(chain_sel), 32'h0);
        scan_dr(64'h5, 4);
        chk("undef_bypass", 32'(obs[3:0]), 32'hA);
        chk("undef_strobes", 32'(n_cap + n_sh + n_upd), 32'd0);

        // Five TMS=1 from SH_DR reach TLR and restore IDCODE.
        step(1, 0); step(0, 0); step(0, 0);
        chk("in_shdr_lit", 32'(tap_state), 32'h2);
        repeat (5) step(1, 0);
        chk("tms5_state_lit", 32'(tap_state), 32'hF);
        chk("tms5_tlr_lit", 32'(tlr), 32'h1);
        step(0, 0);
        scan_dr(64'h0, 32);
        chk("idcode_after_tlr", obs[31:0], 32'h1495_11C3);

        // Reset mid-SH_IR after 2 of 4 bits.
        load_ir(32'h5);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1);
        trst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("trst_state_lit", 32'(tap_state), 32'hF);
        chk("trst_oe_lit", 32'(tdo_oe), 32'h0);
        @(negedge tck);
        @(negedge tck);
        #1;
        compare_all();
        trst_n = 1'b1;
        step(0, 0);
        scan_dr(64'h0, 32);
        chk("idcode_after_trst", obs[31:0], 32'h1495_11C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
